xin_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the two-flop OR-latch stage and drives its `xin` input. It synchronises a raw asynchronous input `din` into the `clk` domain with a two-flop synchroniser. It then debounces the signal with a counter-based state machine and presents a clean level `xout`. It also produces single-cycle `rise`/`fall` strobes and a wrapping count of accepted rising edges for observability.

---
 rtl/xin_debounce.sv | 115 +++++++++++
 tb/tb_xin_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xin_debounce.sv
// Input conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// edge strobes and a wrapping count of accepted rising edges.
//
// state       | meaning
// LOW_STABLE  | xout=0 accepted; waiting for a high sample
// WAIT_HIGH   | counting consecutive high samples toward acceptance
// HIGH_STABLE | xout=1 accepted; waiting for a low sample
// WAIT_LOW    | counting consecutive low samples toward acceptance
module xin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             xout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    WAIT_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             s1_q;
  logic             s2_q;
  logic             xout_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] rise_cnt_q;
  logic [CNT_W-1:0] rise_cnt_d;

  assign cnt_d      = cnt_q + CW'(1);
  assign rise_cnt_d = rise_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= LOW_STABLE;
      cnt_q      <= '0;
      xout_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW_STABLE: begin
          if (s2_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CW'(1);
          end
        end
        WAIT_HIGH: begin
          // any single low sample restarts qualification from the stable state
          if (!s2_q) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= HIGH_STABLE;
            xout_q     <= 1'b1;
            rise_q     <= 1'b1;
            rise_cnt_q <= rise_cnt_d;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HIGH_STABLE: begin
          if (!s2_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CW'(1);
          end
        end
        WAIT_LOW: begin
          if (s2_q) begin
            state_q <= HIGH_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW_STABLE;
            xout_q  <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= LOW_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign xout     = xout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign rise_cnt = rise_cnt_q;

endmodule

// File: tb/tb_xin_debounce.sv
// Scoreboard bench for xin_debounce: a run-length reference model predicts
// strobes and levels; a negedge monitor pops and compares.
module tb_xin_debounce;

  localparam int D  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          xout;
  logic          rise;
  logic          fall;
  logic [CW-1:0] rise_cnt;

  always #5 clk = ~clk;

  xin_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .xout     (xout),
    .rise     (rise),
    .fall     (fall),
    .rise_cnt (rise_cnt)
  );

  typedef struct {
    bit is_rise;
    int at_edge;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  edge_no = 0;

  // reference model: 2-sample transport delay, then a run-length rule
  bit  m_pipe[$];
  bit  m_level;
  int  m_run;
  int  m_rises;

  int  n_rise_seen = 0;
  int  n_fall_seen = 0;
  int  last_rise_edge = -1;
  int  last_fall_edge = -1;

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_no);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back(1'b0);
    m_pipe.push_back(1'b0);
    m_level = 1'b0;
    m_run   = 0;
    m_rises = 0;
    exp_q.delete();
  endtask

  task automatic model_step(bit sample);
    bit obs;
    obs = m_pipe.pop_front();
    m_pipe.push_back(sample);
    if (obs != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = obs;
        m_run   = 0;
        if (obs) m_rises++;
        exp_q.push_back('{obs, edge_no, m_rises % (1 << CW)});
      end
    end else begin
      m_run = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        edge_no++;
        model_step(din);
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      check("rise_fall_exclusive", int'(rise & fall), 0);
      check("xout_level", int'(xout), int'(m_level));
      check("rise_cnt_level", int'(rise_cnt), m_rises % (1 << CW));
      while (exp_q.size() > 0 && exp_q[0].at_edge < edge_no) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_strobe: got none, expected %s at edge %0d", e.is_rise ? "rise" : "fall", e.at_edge);
      end
      if (rise || fall) begin
        if (rise) begin n_rise_seen++; last_rise_edge = edge_no; end
        if (fall) begin n_fall_seen++; last_fall_edge = edge_no; end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got rise=%0b fall=%0b, expected none (edge %0d)", rise, fall, edge_no);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_rise", int'(rise), int'(e.is_rise));
          check("strobe_edge", edge_no, e.at_edge);
          check("strobe_rise_cnt", int'(rise_cnt), e.cnt);
        end
      end
    end
  end

  task automatic hold(bit v, int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int r0;
    int f0;
    repeat (2) @(negedge clk);
    check("reset_xout", int'(xout), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_rise_cnt", int'(rise_cnt), 0);
    rst = 1'b0;
    hold(1'b0, 5);

    // clean rise
    k = edge_no + 1;
    hold(1'b1, 10);
    check("clean_rise_edge", last_rise_edge, k + D + 1);
    check("clean_rise_count", n_rise_seen, 1);
    check("clean_rise_cnt", int'(rise_cnt), 1);
    hold(1'b0, 10);
    check("clean_fall_count", n_fall_seen, 1);

    // glitch rejection
    r0 = n_rise_seen;
    repeat (5) begin
      hold(1'b1, 3);
      hold(1'b0, 1);
    end
    hold(1'b0, 8);
    check("glitch_no_rise", n_rise_seen, r0);
    check("glitch_xout", int'(xout), 0);

    // bounce then settle low
    hold(1'b1, 10);
    f0 = n_fall_seen;
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    k = edge_no + 1;
    hold(1'b0, 12);
    check("bounce_one_fall", n_fall_seen - f0, 1);
    check("bounce_fall_edge", last_fall_edge, k + D + 1);
    check("bounce_xout", int'(xout), 0);

    // wrap: five accepted pairs
    r0 = n_rise_seen;
    f0 = n_fall_seen;
    repeat (5) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    check("wrap_rises", n_rise_seen - r0, 5);
    check("wrap_falls", n_fall_seen - f0, 5);
    check("wrap_rise_cnt", int'(rise_cnt), (1 + 1 + 5) % (1 << CW));

    // randomized segments
    repeat (300) hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    hold(1'b1, 10);

    // asynchronous reset mid-cycle with din high and xout high
    check("pre_async_xout", int'(xout), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_xout", int'(xout), 0);
    check("async_rst_rise", int'(rise), 0);
    check("async_rst_fall", int'(fall), 0);
    check("async_rst_rise_cnt", int'(rise_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = edge_no + 1;
    r0 = n_rise_seen;
    hold(1'b1, 10);
    check("held_through_release_edge", last_rise_edge, k + D + 1);
    check("held_through_release_cnt", int'(rise_cnt), 1);

    // reset pulse in the middle of WAIT_HIGH
    hold(1'b0, 10);
    r0 = n_rise_seen;
    din = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    k = edge_no + 1;
    @(negedge clk);
    check("mid_wait_no_strobe", n_rise_seen, r0);
    check("mid_wait_rise_cnt", int'(rise_cnt), 0);
    hold(1'b1, 10);
    check("mid_wait_rise_edge", last_rise_edge, k + D + 1);
    check("mid_wait_one_rise", n_rise_seen - r0, 1);
    check("mid_wait_final_cnt", int'(rise_cnt), 1);

    hold(1'b0, 10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
